fp16_accum_ctrl: RTL
====================

Name: fp16_accum_ctrl

Overview:
Sequencing controller that reduces a stream of fp16 operands into one fp16 sum per group of LEN elements, time-sharing a single combinational fp16 adder instance (addfp16) against an internal accumulator register. It sits between a CNN convolution or partial-product stage and the output writer, doing channel and kernel-tap accumulation. It uses valid/ready handshakes on both sides and runs a small FSM that counts elements, holds the result, and supports flush.

Parameters:
LEN, 4, number of fp16 operands summed per result; legal range 2..256.
CNT_W, $clog2(LEN+1), width of the element counter and of elem_cnt.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous flush: discard any partial sum and any held result
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  controller accepts in_data this cycle
in_data  input  16  fp16 operand (IEEE half: 1 sign, 5 exponent, 10 fraction bits)
out_valid  output  1  out_data holds a completed sum
out_ready  input  1  downstream consumes out_data this cycle
out_data  output  16  fp16 accumulated sum of the last LEN accepted operands
elem_cnt  output  CNT_W  operands accepted in the current group (0..LEN-1)
busy  output  1  high while the state is ACC with elem_cnt>0, or the state is OUT

Behaviour:
- Clocking and reset: single clock. rst is synchronous, active-high, and has priority over everything.
- Reset values:
  - state=IDLE, acc=16'h0000, elem_cnt=0.
  - out_valid=0, out_data=16'h0000, busy=0, in_ready=1.
- Handshake: an input transfer fires when in_valid&&in_ready. An output transfer fires when out_valid&&out_ready. in_ready is combinational from state only and never depends on in_valid.
- States:
  - IDLE/ACC (merged, encoded as ACC): in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1, and out_data is stable until consumed.
- ACC, input transfer with elem_cnt==0: acc<=in_data loaded directly without going through the adder, so -0 and NaN payloads pass through unchanged. Then elem_cnt<=1.
- ACC, input transfer with elem_cnt>0: acc<=addfp16(acc,in_data), elem_cnt<=elem_cnt+1.
- Completing a group: the transfer with elem_cnt==LEN-1 writes acc as above, sets elem_cnt<=0 and goes to OUT. out_valid rises the cycle after the last input transfer, so latency is 1 cycle.
- Sustained throughput: one operand per cycle in ACC. In OUT, inputs are stalled until the output is consumed.
- OUT with an output transfer: go to ACC. in_ready is high on the next cycle. There is no same-cycle bypass of a new operand while out_valid=1.
- OUT without out_ready: hold state; out_data must not change.
- Arithmetic: inherits addfp16 semantics.
  - Sums are truncated, not rounded.
  - NaN yields 16'h7E00. +inf plus -inf yields 16'h7E00.
  - Overflow saturates to signed infinity. An exact-zero result is +0.
  - No exceptions are flagged. NaN and inf propagate through the rest of the group.
- clear, in any state:
  - Next cycle: state=ACC, elem_cnt=0, out_valid=0, acc=0.
  - An input transfer in the same cycle as clear is discarded.
  - A result in OUT is dropped even if out_ready=1 in the same cycle. Downstream must treat that cycle's handshake as not taken.
- rst mid-group or in OUT: same effect as clear, plus out_data is forced to 16'h0000.
- elem_cnt wrap: it never exceeds LEN-1. It returns to 0 on group completion, clear, or rst.

Test Plan:
- LEN=4, out_ready=1, inputs 3C00,4000,4200,4400 (1,2,3,4) on consecutive cycles -> out_valid=1 exactly one cycle after the 4th transfer, out_data=4900 (10.0), in_ready=0 for that cycle, in_ready=1 the following cycle.
- Backpressure: same group with out_ready=0 for 5 cycles -> out_valid and out_data=4900 held constant, in_ready=0 throughout. out_ready=1 completes the transfer, and the next group 3800×4 (0.5×4) gives out_data=4000 (2.0).
- Cancellation and sign: inputs 3C00,BC00,4000,C000 -> out_data=0000 (+0). Separately, a first operand of 8000 followed by three 8000 -> out_data=8000.
- Specials: inputs 3C00,7C00,3C00,3C00 -> 7C00. Inputs 7C00,FC00,3C00,3C00 -> 7E00. Inputs 3C00,7E01,3C00,3C00 -> 7E00.
- Flush: after 2 operands (elem_cnt=2), pulse clear while in_valid=1 -> elem_cnt=0, out_valid=0, and the operand is discarded. The next 4 operands 4000×4 give out_data=4800 (8.0).
- Reset mid-operation: assert rst in OUT holding 4900 -> next cycle out_valid=0, out_data=0000, in_ready=1, elem_cnt=0, busy=0. Input valid with gaps (in_valid toggling) must give the same sums as the back-to-back run.

Source files
------------

// File: rtl/fp16_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_accum_ctrl (with helper addfp16)
//  Brief    : Reduces a stream of fp16 operands into one fp16 sum per group
//             of LEN elements. A single combinational fp16 adder is shared
//             against an accumulator register. Valid/ready on both sides,
//             two-state FSM (ACC / OUT), synchronous flush.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  addfp16 : combinational IEEE half-precision adder, truncating (toward zero)
//  NaN or inf-inf -> 16'h7E00, overflow -> signed inf, exact cancel -> +0.
// ----------------------------------------------------------------------------
module addfp16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_swap, w_sub, w_sticky;
  logic [15:0] w_big, w_sml;
  logic [4:0]  w_big_e, w_sml_e, w_diff, w_shift;
  logic [13:0] w_big_x, w_sml_x, w_mask, w_sml_al;
  logic [14:0] w_sum;
  logic [3:0]  w_lz;
  logic [5:0]  w_exp;
  logic [10:0] w_mant;

  assign w_a_nan = (&i_a[14:10]) & (|i_a[9:0]);
  assign w_b_nan = (&i_b[14:10]) & (|i_b[9:0]);
  assign w_a_inf = (&i_a[14:10]) & ~(|i_a[9:0]);
  assign w_b_inf = (&i_b[14:10]) & ~(|i_b[9:0]);

  // Order operands by magnitude so the aligned difference is never negative.
  assign w_swap  = i_b[14:0] > i_a[14:0];
  assign w_big   = w_swap ? i_b : i_a;
  assign w_sml   = w_swap ? i_a : i_b;

  // Subnormals share the exponent of the smallest normal, with no hidden one.
  assign w_big_e = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
  assign w_sml_e = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
  assign w_big_x = {|w_big[14:10], w_big[9:0], 3'b000};
  assign w_sml_x = {|w_sml[14:10], w_sml[9:0], 3'b000};
  assign w_diff  = w_big_e - w_sml_e;

  // Three guard bits plus a sticky LSB keep truncation exact on subtraction.
  assign w_mask   = (w_diff >= 5'd14) ? 14'h3FFF : ((14'd1 << w_diff) - 14'd1);
  assign w_sticky = |(w_sml_x & w_mask);
  assign w_sml_al = ((w_diff >= 5'd14) ? 14'd0 : (w_sml_x >> w_diff)) | {13'd0, w_sticky};
  assign w_sub    = w_big[15] ^ w_sml[15];
  assign w_sum    = w_sub ? ({1'b0, w_big_x} - {1'b0, w_sml_al})
                          : ({1'b0, w_big_x} + {1'b0, w_sml_al});

  // Leading-zero count over the 14-bit non-carry field.
  always_comb begin
    w_lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (w_sum[i]) w_lz = 4'(13 - i);
    end
  end

  // Left shift stops at the subnormal boundary so tiny results stay exact.
  assign w_shift = ({1'b0, w_lz} < (w_big_e - 5'd1)) ? {1'b0, w_lz} : (w_big_e - 5'd1);

  // Normalize and truncate the mantissa, then resolve exponent.
  always_comb begin
    w_mant = 11'd0;
    w_exp  = 6'd0;
    if (w_sum[14]) begin
      w_mant = w_sum[14:4];
      w_exp  = {1'b0, w_big_e} + 6'd1;
    end else begin
      w_mant = 11'((w_sum[13:0] << w_shift) >> 3);
      w_exp  = w_mant[10] ? ({1'b0, w_big_e} - {1'b0, w_shift}) : 6'd0;
    end
  end

  // Special-value handling takes priority over the finite datapath.
  always_comb begin
    o_sum = {w_big[15], w_exp[4:0], w_mant[9:0]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] ^ i_b[15]))) begin
      o_sum = 16'h7E00;
    end else if (w_a_inf) begin
      o_sum = i_a;
    end else if (w_b_inf) begin
      o_sum = i_b;
    end else if (w_sum == 15'd0) begin
      // Only -0 + -0 keeps a negative sign; every other zero is +0.
      o_sum = {i_a[15] & i_b[15], 15'd0};
    end else if (w_exp >= 6'd31) begin
      o_sum = {w_big[15], 5'h1F, 10'd0};
    end
  end

endmodule

// ----------------------------------------------------------------------------
//  fp16_accum_ctrl : group accumulator controller
// ----------------------------------------------------------------------------
module fp16_accum_ctrl #(
  parameter int LEN   = 4,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [15:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [15:0]      o_out_data,
  output logic [CNT_W-1:0] o_elem_cnt,
  output logic             o_busy
);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_acc, w_acc_nxt, w_add_sum;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_in_fire, w_out_fire;

  addfp16 u_add (
    .i_a   (r_acc),
    .i_b   (i_in_data),
    .o_sum (w_add_sum)
  );

  assign o_in_ready  = (r_state == S_ACC);
  assign o_out_valid = (r_state == S_OUT);
  assign o_out_data  = r_acc;
  assign o_elem_cnt  = r_cnt;
  assign o_busy      = (r_state == S_OUT) || (r_cnt != '0);
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = o_out_valid & i_out_ready;

  // State, accumulator and element counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACC;
      r_acc   <= 16'h0000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; clear overrides any handshake in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (i_clear) begin
      w_state_nxt = S_ACC;
      w_acc_nxt   = 16'h0000;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_in_fire) begin
            // First operand bypasses the adder so -0 and NaN payloads survive.
            w_acc_nxt = (r_cnt == '0) ? i_in_data : w_add_sum;
            if (r_cnt == c_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_OUT;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (w_out_fire) w_state_nxt = S_ACC;
        end
        default: w_state_nxt = S_ACC;
      endcase
    end
  end

endmodule
`default_nettype wire
